core_ctrl_fsm: RTL and testbench
================================

Name: core_ctrl_fsm

Overview:
- Multicycle control sequencer for the intro RV32 core.
- Owns the single shared memory port, which it uses for both instruction fetch and data access.
- Drives the decoder read-enable, and sequences the operations the decoder produces (ADDI, LUI, SB, LBU, BEQ, BNE, JAL, JALR) through EXEC / MEM / WB steps.
- Generates the datapath strobes: PC update, register-file write, write-back select, and memory request.

Parameters:
MEM_TIMEOUT, 16, max cycles a memory request may wait for mem_ready_i before bus error (>=1)
CNT_W, 32, width of retired-instruction counter

Ports:
clk_i  in  1  clock, all state updates on rising edge
rstn_i  in  1  reset, synchronous, active-low
run_i  in  1  start/continue execution; sampled at IDLE and at instruction retire
mem_ready_i  in  1  memory completion pulse: read data valid / write accepted
opcode_i  in  t_risc_v_op  registered opcode from decoder, valid in DECODE onward
br_eq_i  in  1  datapath comparator rs1==rs2, valid in EXEC
dec_rd_en_o  out  1  decoder capture enable
mem_req_o  out  1  memory request
mem_we_o  out  1  1 = store byte (SB)
mem_addr_sel_o  out  1  0 = PC, 1 = ALU result (rs1+imm)
pc_we_o  out  1  PC register write strobe
pc_sel_o  out  t_pc_sel  PC_PLUS4, PC_BRANCH (PC+imm_b), PC_JAL (PC+imm_j), PC_JALR ((rs1+imm_i)&~1)
rf_we_o  out  1  register-file write strobe (regfile ignores x0)
wb_sel_o  out  t_wb_sel  WB_ALU, WB_IMM_U, WB_MEM_BU (zero-extended byte), WB_PC4
retire_o  out  1  one-cycle pulse per completed instruction
instr_cnt_o  out  CNT_W  retired-instruction count
illegal_o  out  1  sticky, UNKNOWN opcode decoded
bus_err_o  out  1  sticky, memory timeout
state_o  out  3  current t_ctrl_state, for debug

Behaviour:
- Reset (rstn_i=0 at edge): state=IDLE; counter, timeout counter, illegal_o, bus_err_o = 0. All strobes are 0 in IDLE. Reset mid-instruction aborts it with no PC/RF write.
- Control outputs are decoded combinationally from the registered state. Exception: dec_rd_en_o = (state==FETCH) & mem_ready_i, i.e. same cycle as the data.
- IDLE: if run_i=1, go to FETCH.
- FETCH:
  - Drive mem_req_o=1, mem_we_o=0, mem_addr_sel_o=0.
  - On mem_ready_i, go to DECODE.
- DECODE: one cycle, no strobes.
  - If opcode_i==UNKNOWN: set illegal_o and go to HALT.
  - Otherwise go to EXEC.
- EXEC:
  - ADDI/LUI/JAL/JALR: go to WB.
  - SB/LBU: go to MEM.
  - BEQ/BNE: pc_we_o=1. pc_sel_o=PC_BRANCH if taken (BEQ: br_eq_i; BNE: !br_eq_i), else PC_PLUS4. Retire.
  - NOP: pc_we_o=1, PC_PLUS4, retire.
- MEM:
  - Drive mem_req_o=1, mem_addr_sel_o=1, mem_we_o=(op==SB).
  - On mem_ready_i: LBU goes to WB; SB does pc_we_o=1, PC_PLUS4, retire.
- WB: rf_we_o=1 and pc_we_o=1, retire. Selects by op:
  - ADDI: wb_sel_o=WB_ALU, pc_sel_o=PC_PLUS4.
  - LUI: WB_IMM_U, PC_PLUS4.
  - LBU: WB_MEM_BU, PC_PLUS4.
  - JAL: WB_PC4, PC_JAL.
  - JALR: WB_PC4, PC_JALR.
- Retire cycle: retire_o=1 and instr_cnt_o increments, wrapping at 2^CNT_W-1 to 0. Next state is FETCH if run_i=1, else IDLE.
- run_i deasserted mid-instruction has no effect until retire.
- Timeout counter:
  - Cleared on entry to FETCH/MEM; increments each cycle in FETCH/MEM with mem_ready_i=0.
  - When it reaches MEM_TIMEOUT without ready: bus_err_o=1, go to HALT, no strobes.
  - mem_ready_i on that same cycle wins: no error.
- mem_ready_i outside FETCH/MEM is ignored.
- HALT: all strobes 0; held until reset.
- Latency with mem_ready_i in the first request cycle:
  - Branch: 3 cycles.
  - ADDI/LUI/JAL/JALR/SB: 4 cycles.
  - LBU: 5 cycles.
- Each extra memory wait cycle adds 1.

Decomposition:
- riscv_pkg gains t_ctrl_state (IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT; 3-bit), t_pc_sel, and t_wb_sel.
- t_risc_v_op is reused unchanged.
- One sub-module: mem_timeout_ctr (clear/enable/expired, parameter MEM_TIMEOUT).

Test Plan:
- Reset then run_i=1, ADDI, ready at first FETCH cycle:
  - dec_rd_en_o pulses in cycle 1.
  - WB in cycle 4 with rf_we_o=1, wb_sel_o=WB_ALU, pc_sel_o=PC_PLUS4.
  - instr_cnt_o=1.
- BEQ with br_eq_i=1, then BNE with br_eq_i=1:
  - First gives pc_sel_o=PC_BRANCH in EXEC (cycle 3); second gives PC_PLUS4.
  - rf_we_o never asserted.
- LBU with MEM ready delayed 3 cycles:
  - mem_req_o=1 with mem_addr_sel_o=1, mem_we_o=0 for 4 cycles.
  - Then WB with wb_sel_o=WB_MEM_BU; total 8 cycles.
- SB: MEM with mem_we_o=1; retire with pc_we_o=1, no rf_we_o. JALR: WB with wb_sel_o=WB_PC4, pc_sel_o=PC_JALR.
- opcode_i=UNKNOWN: illegal_o=1, state_o=HALT and held with run_i=1. Reset clears illegal_o; state_o=IDLE.
- MEM_TIMEOUT=4, mem_ready_i held 0 in FETCH: bus_err_o=1 after 4 cycles, HALT. Repeat with ready in the 4th cycle: no error. Drop run_i mid-LBU: instruction retires, then IDLE.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared RV32 intro-core types for the decoder and control sequencer
package riscv_pkg;
  typedef enum logic [3:0] {
    NOP, ADDI, LUI, SB, LBU, BEQ, BNE, JAL, JALR, UNKNOWN
  } t_risc_v_op;
  typedef enum logic [2:0] {
    IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT
  } t_ctrl_state;
  typedef enum logic [1:0] {
    PC_PLUS4, PC_BRANCH, PC_JAL, PC_JALR
  } t_pc_sel;
  typedef enum logic [1:0] {
    WB_ALU, WB_IMM_U, WB_MEM_BU, WB_PC4
  } t_wb_sel;
  function automatic logic is_req_state(t_ctrl_state s);
    return (s == FETCH) || (s == MEM);
  endfunction
endpackage

// File: rtl/mem_timeout_ctr.sv
// mem_timeout_ctr: counts unanswered memory request cycles, flags the last allowed one
module mem_timeout_ctr #(
  parameter int MEM_TIMEOUT = 16
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int W = $clog2(MEM_TIMEOUT + 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk_i) begin
    if (!rstn_i || clear) cnt <= '0;
    else if (enable) cnt <= cnt + 1'b1;
  end
  // this cycle would be the MEM_TIMEOUT-th wait without ready
  assign expired = enable && (cnt == W'(MEM_TIMEOUT - 1));
endmodule

// File: rtl/core_ctrl_fsm.sv
// core_ctrl_fsm: multicycle fetch/decode/exec/mem/wb sequencer for the intro RV32 core
module core_ctrl_fsm
  import riscv_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W = 32
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             run_i,
  input  logic             mem_ready_i,
  input  t_risc_v_op       opcode_i,
  input  logic             br_eq_i,
  output logic             dec_rd_en_o,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             mem_addr_sel_o,
  output logic             pc_we_o,
  output t_pc_sel          pc_sel_o,
  output logic             rf_we_o,
  output t_wb_sel          wb_sel_o,
  output logic             retire_o,
  output logic [CNT_W-1:0] instr_cnt_o,
  output logic             illegal_o,
  output logic             bus_err_o,
  output logic [2:0]       state_o
);
  t_ctrl_state state, nxt;
  logic set_ill, set_err, expired, in_req;
  assign in_req = is_req_state(state);
  assign dec_rd_en_o = (state == FETCH) && mem_ready_i;
  assign state_o = state;
  mem_timeout_ctr #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_tmo (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .clear  (!in_req || mem_ready_i),
    .enable (in_req && !mem_ready_i),
    .expired(expired)
  );
  always_comb begin
    nxt = state;
    mem_req_o = 1'b0;
    mem_we_o = 1'b0;
    mem_addr_sel_o = 1'b0;
    pc_we_o = 1'b0;
    pc_sel_o = PC_PLUS4;
    rf_we_o = 1'b0;
    wb_sel_o = WB_ALU;
    retire_o = 1'b0;
    set_ill = 1'b0;
    set_err = 1'b0;
    unique case (state)
      IDLE: nxt = run_i ? FETCH : IDLE;
      FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) nxt = DECODE;
        else if (expired) begin
          set_err = 1'b1;
          nxt = HALT;
        end
      end
      DECODE: begin
        set_ill = (opcode_i == UNKNOWN);
        nxt = set_ill ? HALT : EXEC;
      end
      EXEC: begin
        unique case (opcode_i)
          ADDI, LUI, JAL, JALR: nxt = WB;
          SB, LBU: nxt = MEM;
          BEQ, BNE: begin
            pc_we_o = 1'b1;
            pc_sel_o = ((opcode_i == BEQ) == br_eq_i) ? PC_BRANCH : PC_PLUS4;
            retire_o = 1'b1;
          end
          NOP: begin
            pc_we_o = 1'b1;
            retire_o = 1'b1;
          end
          default: begin
            set_ill = 1'b1;
            nxt = HALT;
          end
        endcase
      end
      MEM: begin
        mem_req_o = 1'b1;
        mem_addr_sel_o = 1'b1;
        mem_we_o = (opcode_i == SB);
        if (mem_ready_i) begin
          pc_we_o = mem_we_o;
          retire_o = mem_we_o;
          nxt = mem_we_o ? state : WB;
        end else if (expired) begin
          set_err = 1'b1;
          nxt = HALT;
        end
      end
      WB: begin
        rf_we_o = 1'b1;
        pc_we_o = 1'b1;
        retire_o = 1'b1;
        wb_sel_o = (opcode_i == LUI) ? WB_IMM_U :
                   (opcode_i == LBU) ? WB_MEM_BU :
                   (opcode_i == JAL || opcode_i == JALR) ? WB_PC4 : WB_ALU;
        pc_sel_o = (opcode_i == JAL) ? PC_JAL : (opcode_i == JALR) ? PC_JALR : PC_PLUS4;
      end
      HALT: nxt = HALT;
      default: nxt = HALT;
    endcase
    if (retire_o) nxt = run_i ? FETCH : IDLE;
  end
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state <= IDLE;
      instr_cnt_o <= '0;
      illegal_o <= 1'b0;
      bus_err_o <= 1'b0;
    end else begin
      state <= nxt;
      if (retire_o) instr_cnt_o <= instr_cnt_o + 1'b1;
      illegal_o <= illegal_o | set_ill;
      bus_err_o <= bus_err_o | set_err;
    end
  end
endmodule

// File: tb/tb_core_ctrl_fsm.sv
// tb_core_ctrl_fsm: randomized scoreboard bench for the control sequencer
module tb_core_ctrl_fsm;
  import riscv_pkg::*;
  localparam int TO = 4;
  logic clk_i = 1'b0, rstn_i, run_i, mem_ready_i, br_eq_i;
  t_risc_v_op opcode_i;
  logic dec_rd_en_o, mem_req_o, mem_we_o, mem_addr_sel_o, pc_we_o, rf_we_o, retire_o;
  logic illegal_o, bus_err_o;
  t_pc_sel pc_sel_o;
  t_wb_sel wb_sel_o;
  logic [31:0] instr_cnt_o;
  logic [2:0] state_o;

  core_ctrl_fsm #(.MEM_TIMEOUT(TO), .CNT_W(32)) dut (
    .clk_i(clk_i), .rstn_i(rstn_i), .run_i(run_i), .mem_ready_i(mem_ready_i),
    .opcode_i(opcode_i), .br_eq_i(br_eq_i), .dec_rd_en_o(dec_rd_en_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_sel_o(mem_addr_sel_o),
    .pc_we_o(pc_we_o), .pc_sel_o(pc_sel_o), .rf_we_o(rf_we_o), .wb_sel_o(wb_sel_o),
    .retire_o(retire_o), .instr_cnt_o(instr_cnt_o), .illegal_o(illegal_o),
    .bus_err_o(bus_err_o), .state_o(state_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int lat;
    t_pc_sel pc_sel;
    bit rf_we;
    t_wb_sel wb_sel;
    int memc;
    bit we;
    logic [31:0] cnt;
  } exp_t;
  exp_t sb_q[$];
  int n_chk = 0, n_fail = 0;
  logic [31:0] exp_cnt;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Spec-level expectation for one instruction given its memory wait counts
  function automatic exp_t model(t_risc_v_op op, bit eq, int fw, int mw, logic [31:0] c);
    exp_t e;
    bit mop = (op == SB) || (op == LBU);
    e.lat = ((op == BEQ || op == BNE || op == NOP) ? 3 : (op == LBU) ? 5 : 4) + fw + (mop ? mw : 0);
    e.pc_sel = (op == JAL) ? PC_JAL : (op == JALR) ? PC_JALR :
               ((op == BEQ && eq) || (op == BNE && !eq)) ? PC_BRANCH : PC_PLUS4;
    e.rf_we = op inside {ADDI, LUI, LBU, JAL, JALR};
    e.wb_sel = (op == LUI) ? WB_IMM_U : (op == LBU) ? WB_MEM_BU :
               (op == JAL || op == JALR) ? WB_PC4 : WB_ALU;
    e.memc = mop ? mw + 1 : 0;
    e.we = (op == SB);
    e.cnt = c;
    return e;
  endfunction

  int lat, memc, decc;
  bit we_seen;
  always @(negedge clk_i) begin
    exp_t e;
    bit bad;
    #2;
    if (!rstn_i) begin
      lat = 0; memc = 0; decc = 0; we_seen = 0;
    end else begin
      if (state_o != IDLE && state_o != HALT) lat++;
      if (mem_req_o && mem_addr_sel_o) begin
        memc++;
        we_seen |= mem_we_o;
      end
      if (dec_rd_en_o) decc++;
      bad = (rf_we_o && !retire_o) || (mem_we_o && !(mem_req_o && mem_addr_sel_o)) ||
            ((state_o == IDLE || state_o == HALT) &&
             (mem_req_o || pc_we_o || rf_we_o || retire_o || dec_rd_en_o));
      chk("strobe_rules", 32'(bad), 0);
      if (retire_o) begin
        if (sb_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_retire: got retire expected none at %0t", $time);
        end else begin
          e = sb_q.pop_front();
          chk("latency", lat, e.lat);
          chk("pc_we", 32'(pc_we_o), 1);
          chk("pc_sel", 32'(pc_sel_o), 32'(e.pc_sel));
          chk("rf_we", 32'(rf_we_o), 32'(e.rf_we));
          if (e.rf_we) chk("wb_sel", 32'(wb_sel_o), 32'(e.wb_sel));
          chk("mem_cycles", memc, e.memc);
          chk("mem_we", 32'(we_seen), 32'(e.we));
          chk("dec_rd_en_pulses", decc, 1);
          chk("instr_cnt", instr_cnt_o, e.cnt);
        end
        lat = 0; memc = 0; decc = 0; we_seen = 0;
      end
    end
  end

  task automatic do_instr(t_risc_v_op op, bit eq, int fw, int mw, bit run_next, bit drop);
    int fc = 0, mc = 0, t = 0;
    bit done = 0;
    sb_q.push_back(model(op, eq, fw, mw, exp_cnt));
    exp_cnt++;
    run_i = 1'b1;
    while (!done && t < 100) begin
      @(negedge clk_i);
      t++;
      mem_ready_i = 1'b0;
      if (mem_req_o && !mem_addr_sel_o) begin
        if (fc == 0) begin
          opcode_i = op;
          br_eq_i = eq;
        end
        mem_ready_i = (fc == fw);
        fc++;
      end else if (mem_req_o) begin
        if (drop) run_i = 1'b0;
        mem_ready_i = (mc == mw);
        mc++;
      end
      #1;
      if (retire_o) begin
        run_i = run_next;
        done = 1;
      end
    end
    if (!done) begin
      n_chk++; n_fail++;
      $display("FAIL retire_wait: got no retire expected retire for op %s", op.name());
    end
    if (!run_next) begin
      @(negedge clk_i);
      mem_ready_i = 1'b0;
      #1 chk("idle_after_stop", state_o, IDLE);
    end
  endtask

  task automatic do_reset();
    rstn_i = 1'b0; run_i = 1'b0; mem_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    #1;
    chk("rst_state", state_o, IDLE);
    chk("rst_cnt", instr_cnt_o, 0);
    chk("rst_illegal", 32'(illegal_o), 0);
    chk("rst_bus_err", 32'(bus_err_o), 0);
    chk("rst_mem_req", 32'(mem_req_o), 0);
    exp_cnt = 0;
    rstn_i = 1'b1;
  endtask

  t_risc_v_op ops[9];
  initial begin
    ops = '{NOP, ADDI, LUI, SB, LBU, BEQ, BNE, JAL, JALR};
    opcode_i = NOP; br_eq_i = 1'b0;
    do_reset();
    @(negedge clk_i);
    #1 chk("idle_hold", state_o, IDLE);
    do_instr(ADDI, 0, 0, 0, 1, 0);
    do_instr(BEQ, 1, 0, 0, 1, 0);
    do_instr(BNE, 1, 0, 0, 1, 0);
    do_instr(LBU, 0, 0, 3, 1, 0);
    do_instr(SB, 0, 0, 1, 1, 0);
    do_instr(JALR, 0, 0, 0, 1, 0);
    do_instr(LUI, 0, 1, 0, 1, 0);
    do_instr(JAL, 0, 0, 0, 1, 0);
    do_instr(NOP, 0, 2, 0, 1, 0);
    do_instr(BNE, 0, 0, 0, 1, 0);
    do_instr(ADDI, 0, TO - 1, 0, 1, 0);
    do_instr(LBU, 1, 0, TO - 1, 0, 1);
    for (int i = 0; i < 60; i++)
      do_instr(ops[$urandom_range(0, 8)], 1'($urandom_range(0, 1)), $urandom_range(0, TO - 1),
               $urandom_range(0, TO - 1), (i != 59) && ($urandom_range(0, 7) != 0), 0);
    chk("no_bus_err", 32'(bus_err_o), 0);
    chk("no_illegal", 32'(illegal_o), 0);
    chk("sb_empty", sb_q.size(), 0);
    run_i = 1'b1;
    @(negedge clk_i);
    opcode_i = UNKNOWN;
    mem_ready_i = 1'b1;
    @(negedge clk_i);
    mem_ready_i = 1'b0;
    #1 chk("decode_state", state_o, DECODE);
    @(negedge clk_i);
    #1 chk("illegal_set", 32'(illegal_o), 1);
    chk("illegal_halt", state_o, HALT);
    repeat (3) begin
      @(negedge clk_i);
      mem_ready_i = ~mem_ready_i;
    end
    #1 chk("halt_held", state_o, HALT);
    chk("halt_cnt", instr_cnt_o, exp_cnt);
    do_reset();
    run_i = 1'b1;
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk_i);
      #1 chk("tmo_wait_err", 32'(bus_err_o), 0);
      chk("tmo_wait_state", state_o, FETCH);
    end
    @(negedge clk_i);
    #1 chk("tmo_err", 32'(bus_err_o), 1);
    chk("tmo_halt", state_o, HALT);
    do_reset();
    do_instr(JAL, 0, 0, 0, 0, 0);
    chk("post_rst_cnt", instr_cnt_o, 1);
    chk("sb_final_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
